// File: rtl/seq_wide_alu.sv
// Multi-cycle wide ALU: add/subtract in one cycle, multiply DIGIT bits of operand2 per cycle.
// start/busy/done handshake; result is registered and held between operations.
module seq_wide_alu #(
  parameter int WIDTH = 512,
  parameter int DIGIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           operation,
  input  logic [WIDTH-1:0]     operand1,
  input  logic [WIDTH-1:0]     operand2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int ACC_W  = 2 * WIDTH;
  localparam int N_ITER = WIDTH / DIGIT;
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_SUB = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [ACC_W-1:0]   a_q, a_d;         // operand1, shifted left one digit per multiply step
  logic [WIDTH-1:0]   b_q, b_d;         // operand2, shifted right one digit per multiply step
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   partial;

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred; blocking assignments are correct in
  // combinational logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    partial  = a_q * ACC_W'(b_q[DIGIT-1:0]);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (start) begin
          op_d    = op_e'(operation);
          a_d     = ACC_W'(operand1);
          b_d     = operand2;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (op_e'(operation) == OP_MUL) ? ST_MUL : ST_EXEC;
        end
      end

      ST_EXEC: begin
        unique case (op_q)
          OP_ADD:  result_d = a_q + ACC_W'(b_q);
          // Subtracting in the full accumulator width sign-extends a negative difference.
          OP_SUB:  result_d = a_q - ACC_W'(b_q);
          default: result_d = '0;
        endcase
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      ST_MUL: begin
        acc_d = acc_q + partial;
        a_d   = a_q << DIGIT;
        b_d   = b_q >> DIGIT;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          result_d = acc_q + partial;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/seq_wide_alu.md
Name: seq_wide_alu

Overview:
- Parametrised, multi-cycle successor to the team's wide combinational add/multiply ALU.
- Adds a subtract mode and a start/busy/done handshake.
- Multiplication is iterative: DIGIT bits of operand2 are consumed per cycle, so a 512-bit multiply does not require a single-cycle 512x512 array.
- Sits between the big-number controller and its operand/result registers. The controller issues one operation at a time and waits for done.

Parameters:
- WIDTH, 512, operand width in bits. Must be divisible by DIGIT.
- DIGIT, 8, operand2 bits consumed per multiply iteration. Range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- operation  input  2  00 add, 01 multiply, 10 subtract, 11 reserved
- operand1  input  WIDTH  first operand, unsigned
- operand2  input  WIDTH  second operand, unsigned
- busy  output  1  operation in progress; start ignored while high
- done  output  1  one-cycle pulse: result valid
- result  output  2*WIDTH  registered result, held until the next accepted start or reset

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: busy=0, done=0, result=0, state=IDLE, iteration counter=0, internal operand latches=0.
- States:
  - IDLE: waiting for a request.
  - EXEC: add, subtract or reserved; lasts 1 cycle.
  - MUL: lasts WIDTH/DIGIT cycles.
  - DONE: lasts 1 cycle.
- Accept rule: start=1 at an edge while state is IDLE or DONE.
  - operation, operand1 and operand2 are latched internally at that edge.
  - busy goes 1 and done goes 0.
  - Next state is MUL for operation 01, otherwise EXEC.
  - Inputs may change after the accept edge.
- EXEC, one edge:
  - 00: result = zero-extended operand1 + operand2, including carry at bit WIDTH.
  - 10: result = (operand1 - operand2) mod 2^(2*WIDTH), i.e. the negative difference is sign-extended to all 2*WIDTH bits.
  - 11: result = 0.
  - Then go to DONE.
- MUL, iteration k = 0 .. WIDTH/DIGIT-1:
  - acc += (operand1 * operand2[k*DIGIT +: DIGIT]) << (k*DIGIT).
  - The accumulator is 2*WIDTH bits wide, is cleared at accept, and never overflows.
  - On the edge that completes the final iteration, result = acc and the next state is DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
  - With no start, the next state is IDLE and done falls to 0; result is held.
  - With start=1 in the DONE cycle, a new request is accepted back-to-back.
- Latency, counted in edges from the accept edge to the edge that raises done:
  - add, subtract, reserved: 2.
  - multiply: WIDTH/DIGIT + 1, which is 65 at the defaults.
- busy is 1 from the edge after accept until the edge that raises done.
- start while busy=1 is ignored: no effect on state, latched operands or result.
- Reset asserted in any state, including mid-multiply, aborts the operation. The following cycle shows the reset values, with no done pulse.
- The result register is not updated until the operation completes; intermediate accumulator values are never visible on result.

Test Plan:
- WIDTH=16, DIGIT=4, add: 0xFFFF + 0x0001 -> result 0x0001_0000, done exactly 2 edges after accept, busy high for 1 cycle.
- WIDTH=16, DIGIT=4, subtract: 0x0001 - 0x0002 -> result 0xFFFF_FFFF. Then 0x1234 - 0x0234 -> 0x0000_1000.
- WIDTH=16, DIGIT=4, multiply: 0xFFFF * 0xFFFF -> 0xFFFE_0001, done 5 edges after accept. Operands changed and start pulsed again mid-operation -> ignored, result unchanged.
- Defaults (512/8), multiply: all-ones * all-ones -> 2^1024 - 2^513 + 1, done 65 edges after accept. Also 0 * X -> 0 and 1 * X -> X.
- Back-to-back: start held high in the DONE cycle with operation 00 -> new add accepted, done pulses separated by exactly 2 cycles. Operation 11 -> result 0 after 2 edges.
- Reset asserted at iteration 3 of a 512-bit multiply -> next cycle busy=0, done=0, result=0. No done pulse follows. A fresh add afterwards completes normally.
